// File: rtl/inj_bank_driver.sv
// N-channel fuel injector pulse generator: per-channel phase match, batch/sequential firing, exact-width pulses.
// Optional INJ_BANK_DEADTIME_EN adds a saturating opening-time compensation input "deadtime".
module inj_bank_driver #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int PH_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   trigger,
  input  logic [PH_W-1:0]        eng_phase,
  input  logic                   mode,
  input  logic [N_CH-1:0]        ch_en,
  input  logic [N_CH*PH_W-1:0]   ch_phase,
  input  logic [N_CH-1:0]        ch_cycle,
  input  logic [N_CH*CNT_W-1:0]  on_cycles,
`ifdef INJ_BANK_DEADTIME_EN
  input  logic [CNT_W-1:0]       deadtime,
`endif
  input  logic                   overlap_clr,
  output logic [N_CH-1:0]        inj_out,
  output logic [N_CH-1:0]        busy,
  output logic [N_CH-1:0]        overlap
);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic                        cyc_p1;
  logic [N_CH-1:0]             active_p1;
  logic [N_CH-1:0][CNT_W-1:0]  rem_p1;
  logic [N_CH-1:0]             overlap_p1;

  logic                        vld_p0;
  logic                        wrap_p0;
  logic                        cyc_eff_p0;
  logic [N_CH-1:0]             fire_p0;
  logic [N_CH-1:0]             reload_p0;
  logic [N_CH-1:0]             ovl_set_p0;
  logic [N_CH-1:0][CNT_W-1:0]  width_p0;

  // Stage p0: phase match and pulse-width selection for this cycle's trigger
  always_comb begin
    vld_p0     = trigger;
    wrap_p0    = trigger && (eng_phase == '0);
    cyc_eff_p0 = wrap_p0 ? ~cyc_p1 : cyc_p1;
    fire_p0    = '0;
    reload_p0  = '0;
    ovl_set_p0 = '0;
    width_p0   = '0;
    for (int i = 0; i < N_CH; i++) begin
      fire_p0[i] = vld_p0 && (eng_phase == ch_phase[i*PH_W +: PH_W]) &&
                   (!mode || (ch_cycle[i] == cyc_eff_p0));
`ifdef INJ_BANK_DEADTIME_EN
      width_p0[i] = (on_cycles[i*CNT_W +: CNT_W] == '0) ? '0 :
                    sat_add(on_cycles[i*CNT_W +: CNT_W], deadtime);
`else
      width_p0[i] = sat_add(on_cycles[i*CNT_W +: CNT_W], '0);
`endif
      reload_p0[i]  = fire_p0[i] && (width_p0[i] != '0);
      ovl_set_p0[i] = reload_p0[i] && active_p1[i];
    end
  end

  // Stage p1: pulse state; a reload on the expiry cycle keeps the pulse running
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_p1     <= 1'b0;
      active_p1  <= '0;
      rem_p1     <= '0;
      overlap_p1 <= '0;
    end else begin
      if (wrap_p0) cyc_p1 <= ~cyc_p1;
      overlap_p1 <= ovl_set_p0 | (overlap_p1 & ~{N_CH{overlap_clr}});
      for (int i = 0; i < N_CH; i++) begin
        if (reload_p0[i]) begin
          active_p1[i] <= 1'b1;
          rem_p1[i]    <= width_p0[i];
        end else if (active_p1[i]) begin
          if (rem_p1[i] == CNT_W'(1)) begin
            active_p1[i] <= 1'b0;
            rem_p1[i]    <= '0;
          end else begin
            rem_p1[i]    <= rem_p1[i] - CNT_W'(1);
          end
        end
      end
    end
  end

  assign busy    = active_p1;
  assign inj_out = active_p1 & ch_en & {N_CH{en}};
  assign overlap = overlap_p1;

endmodule

// File: tb/tb_inj_bank_driver.sv
// Randomized bench for inj_bank_driver against a pulse-end-time reference model.
module tb_inj_bank_driver;
  localparam int N_CH  = 4;
  localparam int CNT_W = 32;
  localparam int PH_W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, en, trigger, mode, overlap_clr;
  logic [PH_W-1:0]       eng_phase;
  logic [N_CH-1:0]       ch_en, ch_cycle, inj_out, busy, overlap;
  logic [N_CH*PH_W-1:0]  ch_phase;
  logic [N_CH*CNT_W-1:0] on_cycles;
`ifdef INJ_BANK_DEADTIME_EN
  logic [CNT_W-1:0]      deadtime;
`endif

  inj_bank_driver #(.N_CH(N_CH), .CNT_W(CNT_W), .PH_W(PH_W)) dut (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .eng_phase(eng_phase),
    .mode(mode), .ch_en(ch_en), .ch_phase(ch_phase), .ch_cycle(ch_cycle),
    .on_cycles(on_cycles),
`ifdef INJ_BANK_DEADTIME_EN
    .deadtime(deadtime),
`endif
    .overlap_clr(overlap_clr), .inj_out(inj_out), .busy(busy), .overlap(overlap)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a channel is high during cycle t iff t < off_at[i].
  longint off_at [N_CH];
  bit     ov_m   [N_CH];
  bit     cyc_m;
  longint t;

  function automatic longint width_of(input int i);
    longint oc;
    oc = longint'(on_cycles[i*CNT_W +: CNT_W]);
`ifdef INJ_BANK_DEADTIME_EN
    if (oc == 0) return 0;
    oc = oc + longint'(deadtime);
    if (oc > 64'hFFFF_FFFF) oc = 64'hFFFF_FFFF;
`endif
    return oc;
  endfunction

  task automatic model_step();
    bit eff;
    bit wrap;
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin off_at[i] = 0; ov_m[i] = 0; end
      cyc_m = 0;
      return;
    end
    wrap = trigger && (eng_phase == 0);
    eff  = wrap ? !cyc_m : cyc_m;
    for (int i = 0; i < N_CH; i++) begin
      bit fire;
      bit set;
      longint w;
      w    = width_of(i);
      fire = trigger && (eng_phase == ch_phase[i*PH_W +: PH_W]) &&
             (!mode || (ch_cycle[i] == eff));
      set  = fire && (w != 0) && (t < off_at[i]);
      if (fire && w != 0) off_at[i] = t + 1 + w;
      if (set) ov_m[i] = 1;
      else if (overlap_clr) ov_m[i] = 0;
    end
    if (wrap) cyc_m = !cyc_m;
  endtask

  task automatic compare_all();
    logic [N_CH-1:0] eb, ei, eo;
    for (int i = 0; i < N_CH; i++) begin
      eb[i] = (t < off_at[i]);
      ei[i] = eb[i] && en && ch_en[i];
      eo[i] = ov_m[i];
    end
    check_val("busy", 64'(busy), 64'(eb));
    check_val("inj_out", 64'(inj_out), 64'(ei));
    check_val("overlap", 64'(overlap), 64'(eo));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; trigger = 1'b0; mode = 1'b0; overlap_clr = 1'b0;
    eng_phase = '0; ch_en = '1; ch_cycle = '0; ch_phase = '0; on_cycles = '0;
`ifdef INJ_BANK_DEADTIME_EN
    deadtime = '0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      ch_phase[i*PH_W +: PH_W] = PH_W'(i);
      off_at[i] = 0;
      ov_m[i] = 0;
    end
    cyc_m = 0;
    t = 0;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    for (int k = 0; k < 6000; k++) begin
      rst         = ($urandom_range(0, 299) == 0);
      en          = ($urandom_range(0, 9) != 0);
      trigger     = ($urandom_range(0, 2) == 0);
      eng_phase   = PH_W'($urandom_range(0, 3));
      overlap_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      for (int i = 0; i < N_CH; i++) begin
        int r;
        ch_en[i] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 49) == 0) ch_phase[i*PH_W +: PH_W] = PH_W'($urandom_range(0, 3));
        if ($urandom_range(0, 49) == 0) ch_cycle[i] = ~ch_cycle[i];
        r = $urandom_range(0, 7);
        if (r == 0)      on_cycles[i*CNT_W +: CNT_W] = '0;
        else if (r == 1) on_cycles[i*CNT_W +: CNT_W] = CNT_W'(1);
        else             on_cycles[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(2, 15));
`ifdef INJ_BANK_DEADTIME_EN
        if ($urandom_range(0, 499) == 0) on_cycles[i*CNT_W +: CNT_W] = 32'hFFFF_FFF6;
`endif
      end
`ifdef INJ_BANK_DEADTIME_EN
      deadtime = ($urandom_range(0, 9) == 0) ? CNT_W'(50) : CNT_W'($urandom_range(0, 5));
`endif
      model_step();
      @(posedge clk);
      #1;
      t++;
      compare_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
